// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between two requesters; gnt 2 cycles after req, done 1 cycle after FINISH.
// Requesters hold req until done; launches only when m_ready & !lines_busy, stalls after launch are bounded by the timeout.
module i2c_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata,
  output logic [6:0] m_addr,
  output logic [7:0] m_data_in,
  output logic       m_rw,
  output logic       m_enable,
  input  logic [7:0] m_data_out,
  input  logic       m_ready,
  input  logic       lines_busy,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT_DONE, FINISH} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            last_ptr;
  logic            win, win_nxt;
  logic            err_flag;
  logic            timeout;

  assign timeout = (to_cnt == TO_LAST);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    case (state)
      IDLE: begin
        if ((req0 || req1) && m_ready && !lines_busy) begin
          state_nxt = GRANT;
          // Contention goes to whoever was not served last.
          win_nxt   = (req0 && req1) ? !last_ptr : req1;
        end
      end
      GRANT:     state_nxt = LAUNCH;
      LAUNCH:    if (timeout || !m_ready) state_nxt = timeout ? FINISH : WAIT_DONE;
      WAIT_DONE: if (timeout || m_ready) state_nxt = FINISH;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      last_ptr  <= 1'b1;
      win       <= 1'b0;
      err_flag  <= 1'b0;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata     <= '0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
      m_enable  <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;

      if (state_nxt != state) to_cnt <= '0;
      else if (state == LAUNCH || state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;

      case (state)
        GRANT: begin
          owner     <= win;
          gnt0      <= !win;
          gnt1      <= win;
          m_enable  <= 1'b1;
          err_flag  <= 1'b0;
          m_addr    <= win ? addr1 : addr0;
          m_rw      <= win ? rw1 : rw0;
          m_data_in <= win ? wdata1 : wdata0;
        end
        LAUNCH: begin
          // Enable stays up only until the master shows it has taken the job.
          if (timeout || !m_ready) m_enable <= 1'b0;
          if (timeout) err_flag <= 1'b1;
        end
        WAIT_DONE: begin
          if (timeout) err_flag <= 1'b1;
        end
        FINISH: begin
          done0    <= !owner;
          done1    <= owner;
          err0     <= err_flag && !owner;
          err1     <= err_flag && owner;
          last_ptr <= owner;
          if (m_rw && !err_flag) rdata <= m_data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: vector table, reset corner sequences, randomized round-robin traffic.
module tb_i2c_master_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rw0, rw1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic [7:0] rdata;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_rw, m_enable;
  logic [7:0] m_data_out;
  logic       m_ready;
  logic       lines_busy;
  logic       busy, owner;

  i2c_master_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .rw0(rw0), .rw1(rw1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
    .m_data_out(m_data_out), .m_ready(m_ready), .lines_busy(lines_busy),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r0, r1;
    logic [6:0] a0, a1;
    logic       rw0, rw1;
    logic [7:0] w0, w1;
    int         drop;      // enable-high cycles before the master takes the job; 0 = never
    int         hold;      // cycles the master stays busy
    logic [7:0] rd;
    int         busy_pre;  // cycles lines_busy is held after req rises
    logic       keep;      // loser keeps requesting after done
    logic       exp_win;
    int         exp_lat;   // -1: not checked
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0, gnt_cyc = 0, en_hi = 0, excl_viol = 0, exp_done = 0;
  int gnt_cnt0 = 0, gnt_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;
  int mdrop = 1, mhold = 1, mcnt = 0;
  bit mbusy = 0;
  logic [7:0] mrd = 8'h00;
  logic ref_last;
  logic [7:0] ref_rdata;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Pulse and enable monitor, sampled just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (gnt0) gnt_cnt0++;
    if (gnt1) gnt_cnt1++;
    if (gnt0 || gnt1) gnt_cyc = cyc;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
    if (m_enable) en_hi++;
    if ((gnt0 && gnt1) || (done0 && done1) || (err0 && err1) || (err0 && !done0) || (err1 && !done1))
      excl_viol++;
  end

  // i2c_master model: takes the job after mdrop enable cycles, busy for mhold cycles.
  initial begin
    m_ready = 1'b1;
    m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ready = 1'b1; mbusy = 0; mcnt = 0;
      end else if (!mbusy) begin
        if (m_enable) begin
          mcnt++;
          if (mdrop != 0 && mcnt >= mdrop) begin m_ready = 1'b0; mbusy = 1; mcnt = 0; end
        end else mcnt = 0;
      end else begin
        mcnt++;
        if (mcnt >= mhold) begin m_ready = 1'b1; m_data_out = mrd; mbusy = 0; mcnt = 0; end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  // Round-robin reference: both requesting -> the one not served last; anyone served updates the pointer.
  task automatic predict(inout vec_t v);
    logic sel_rw;
    v.exp_win = (v.r0 && v.r1) ? !ref_last : v.r1;
    ref_last  = v.exp_win;
    sel_rw    = v.exp_win ? v.rw1 : v.rw0;
    v.exp_err = (v.drop == 0 || v.drop >= TO || v.hold >= TO);
    if (sel_rw && !v.exp_err) ref_rdata = v.rd;
    v.exp_rdata = ref_rdata;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int gs, ds, d0s, d1s, es, t0, n, bsy;
    logic w;
    bit got;
    gs = gnt_cnt0 + gnt_cnt1; d0s = done_cnt0; d1s = done_cnt1; ds = d0s + d1s;
    es = err_cnt0 + err_cnt1;
    en_hi = 0; mdrop = v.drop; mhold = v.hold; mrd = v.rd;
    step();
    if (v.busy_pre > 0) lines_busy = 1'b1;
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    rw0 = v.rw0; rw1 = v.rw1; wdata0 = v.w0; wdata1 = v.w1;
    t0 = cyc;
    if (v.busy_pre > 0) begin
      bsy = 0;
      repeat (v.busy_pre) begin step(); bsy = bsy | int'(busy); end
      chk({tag, "_held_gnt"}, gnt_cnt0 + gnt_cnt1 - gs, 0);
      chk({tag, "_held_busy"}, bsy, 0);
      lines_busy = 1'b0;
      t0 = cyc;
    end
    n = 0;
    while (gnt_cnt0 + gnt_cnt1 == gs && n < 40) begin step(); n++; end
    got = (gnt_cnt0 + gnt_cnt1 != gs);
    chk({tag, "_gnt_seen"}, int'(got), 1);
    if (!got) begin req0 = 1'b0; req1 = 1'b0; return; end
    w = (gnt_cnt1 != 0) && (gnt_cyc == cyc) && gnt1;
    chk({tag, "_winner"}, int'(w), int'(v.exp_win));
    if (v.exp_lat >= 0) chk({tag, "_gnt_lat"}, gnt_cyc - t0, v.exp_lat);
    chk({tag, "_m_addr"}, int'(m_addr), int'(v.exp_win ? v.a1 : v.a0));
    chk({tag, "_m_data_in"}, int'(m_data_in), int'(v.exp_win ? v.w1 : v.w0));
    chk({tag, "_m_rw"}, int'(m_rw), int'(v.exp_win ? v.rw1 : v.rw0));
    chk({tag, "_owner"}, int'(owner), int'(v.exp_win));
    n = 0;
    while (done_cnt0 + done_cnt1 == ds && n < 80) begin step(); n++; end
    got = (done_cnt0 + done_cnt1 != ds);
    chk({tag, "_done_seen"}, int'(got), 1);
    if (got) begin
      exp_done++;
      chk({tag, "_done_src"}, done_cnt1 - d1s, v.exp_win ? 1 : 0);
      chk({tag, "_err"}, err_cnt0 + err_cnt1 - es, int'(v.exp_err));
      chk({tag, "_rdata"}, int'(rdata), int'(v.exp_rdata));
      chk({tag, "_en_cycles"}, en_hi, (v.drop == 0 || v.drop >= TO) ? TO : v.drop);
    end
    if (!v.keep || w == 1'b0) req0 = 1'b0;
    if (!v.keep || w == 1'b1) req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; lines_busy = 1'b0;
    repeat (3) step();
    chk("reset_ctl", int'({gnt0, gnt1, done0, done1, err0, err1, m_enable, busy, owner, m_rw}), 0);
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_m_addr", int'(m_addr), 0);
    chk("reset_m_data_in", int'(m_data_in), 0);
    rst = 1'b0;
    step();

    //          r0    r1    a0     a1     rw0   rw1   w0     w1    drop hold rd     bp  keep  win  lat err   rdata
    tbl[0]  = '{1'b1, 1'b0, 7'h01, 7'h00, 1'b0, 1'b0, 8'hCD, 8'h00, 3, 10, 8'hAA, 0,  1'b0, 1'b0, 2, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 7'h00, 7'h02, 1'b0, 1'b1, 8'h00, 8'h00, 3, 10, 8'h55, 0,  1'b0, 1'b1, 2, 1'b0, 8'h55};
    tbl[2]  = '{1'b1, 1'b1, 7'h10, 7'h20, 1'b0, 1'b1, 8'h11, 8'h22, 2, 5,  8'h77, 0,  1'b1, 1'b0, 2, 1'b0, 8'h55};
    tbl[3]  = '{1'b0, 1'b1, 7'h10, 7'h20, 1'b0, 1'b1, 8'h11, 8'h22, 2, 5,  8'h66, 0,  1'b0, 1'b1, -1, 1'b0, 8'h66};
    tbl[4]  = '{1'b1, 1'b1, 7'h30, 7'h40, 1'b1, 1'b0, 8'h33, 8'h44, 4, 3,  8'h99, 0,  1'b0, 1'b0, 2, 1'b0, 8'h99};
    tbl[5]  = '{1'b1, 1'b0, 7'h05, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1,  8'hEE, 0,  1'b0, 1'b0, 2, 1'b1, 8'h99};
    tbl[6]  = '{1'b0, 1'b1, 7'h00, 7'h06, 1'b0, 1'b1, 8'h00, 8'h00, 1, 3,  8'h3C, 0,  1'b0, 1'b1, 2, 1'b0, 8'h3C};
    tbl[7]  = '{1'b1, 1'b0, 7'h07, 7'h00, 1'b0, 1'b0, 8'hB7, 8'h00, 2, 4,  8'h12, 20, 1'b0, 1'b0, 2, 1'b0, 8'h3C};
    tbl[8]  = '{1'b0, 1'b1, 7'h00, 7'h08, 1'b0, 1'b1, 8'h00, 8'h00, 2, 15, 8'hA5, 0,  1'b0, 1'b1, 2, 1'b0, 8'hA5};
    tbl[9]  = '{1'b0, 1'b1, 7'h00, 7'h0A, 1'b0, 1'b1, 8'h00, 8'h00, 15, 2, 8'hC7, 0,  1'b0, 1'b1, 2, 1'b0, 8'hC7};
    tbl[10] = '{1'b1, 1'b0, 7'h09, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 2, 40, 8'h5A, 0,  1'b0, 1'b0, 2, 1'b1, 8'hC7};
    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while launching, then while waiting for the master to finish.
    for (int ph = 0; ph < 2; ph++) begin
      int gs, ds, es, n;
      mdrop = (ph == 0) ? 12 : 2; mhold = 50; mrd = 8'hFF;
      gs = gnt_cnt0 + gnt_cnt1;
      step();
      req0 = 1'b1; addr0 = 7'h11; rw0 = 1'b1; wdata0 = 8'h00;
      n = 0;
      while (gnt_cnt0 + gnt_cnt1 == gs && n < 40) begin step(); n++; end
      chk($sformatf("rst%0d_gnt_seen", ph), gnt_cnt0 + gnt_cnt1 - gs, 1);
      repeat ((ph == 0) ? 3 : 6) step();
      chk($sformatf("rst%0d_pre_busy", ph), int'(busy), 1);
      chk($sformatf("rst%0d_pre_en", ph), int'(m_enable), (ph == 0) ? 1 : 0);
      ds = done_cnt0 + done_cnt1; es = err_cnt0 + err_cnt1;
      rst = 1'b1; req0 = 1'b0;
      step();
      chk($sformatf("rst%0d_ctl", ph), int'({gnt0, gnt1, done0, done1, err0, err1, m_enable, busy, owner, m_rw}), 0);
      chk($sformatf("rst%0d_rdata", ph), int'(rdata), 0);
      chk($sformatf("rst%0d_m_addr", ph), int'(m_addr), 0);
      rst = 1'b0;
      repeat (4) step();
      chk($sformatf("rst%0d_no_done", ph), done_cnt0 + done_cnt1 - ds, 0);
      chk($sformatf("rst%0d_no_err", ph), err_cnt0 + err_cnt1 - es, 0);
    end

    ref_last = 1'b1;
    ref_rdata = 8'h00;
    begin
      vec_t v;
      v = '{1'b1, 1'b1, 7'h21, 7'h22, 1'b1, 1'b1, 8'h00, 8'h00, 1, 2, 8'hC3, 0, 1'b0, 1'b0, 2, 1'b0, 8'h00};
      predict(v);
      run_txn(v, "post_rst");
    end

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.r0 = 1'($urandom_range(0, 1));
      v.r1 = 1'($urandom_range(0, 1));
      if (!v.r0 && !v.r1) v.r1 = 1'b1;
      v.a0 = 7'($urandom); v.a1 = 7'($urandom);
      v.rw0 = 1'($urandom); v.rw1 = 1'($urandom);
      v.w0 = 8'($urandom); v.w1 = 8'($urandom);
      v.drop = int'($urandom_range(0, 5));
      v.hold = int'($urandom_range(1, 8));
      v.rd = 8'($urandom);
      v.busy_pre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      v.keep = 1'b0;
      v.exp_lat = 2;
      predict(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    step();
    chk("pulse_exclusive", excl_viol, 0);
    chk("done_total", done_cnt0 + done_cnt1, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
